// File: rtl/dsp_mac_job_sequencer.sv
// Frames multiply-accumulate jobs onto a dsp_t1_20x18x64 slice and returns one result per job.
// Define DSP_MAC_SEQ_TIMEOUT_EN to abort starved jobs after TIMEOUT_CYCLES idle cycles.
module dsp_mac_job_sequencer #(
    parameter int LEN_W          = 10,
    parameter int DSP_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [5:0]        cmd_shift_i,
    input  logic              cmd_round_i,
    input  logic              cmd_sat_i,
    input  logic [1:0]        cmd_unsigned_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [19:0]       op_a_i,
    input  logic [17:0]       op_b_i,
    output logic [19:0]       dsp_a_o,
    output logic [17:0]       dsp_b_o,
    output logic              dsp_load_acc_o,
    output logic [2:0]        dsp_feedback_o,
    output logic              dsp_unsigned_a_o,
    output logic              dsp_unsigned_b_o,
    output logic [5:0]        dsp_shift_right_o,
    output logic              dsp_round_o,
    output logic              dsp_saturate_o,
    output logic              dsp_subtract_o,
    input  logic [37:0]       dsp_z_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [37:0]       res_data_o,
    output logic              res_err_o
);

    if (DSP_LATENCY < 1 || DSP_LATENCY > 7 || TIMEOUT_CYCLES < 1 || LEN_W < 1) begin : g_bad_params
        $error("dsp_mac_job_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             first;
    logic [2:0]       drain_cnt;
    logic             cmd_fire;
    logic             op_fire;
    logic             last_beat;
    logic             drain_done;
    logic             res_fire;
    logic             timeout_hit;

    assign cmd_ready_o    = (state == IDLE);
    assign op_ready_o     = (state == ISSUE);
    assign cmd_fire       = (state == IDLE) && cmd_valid_i;
    assign op_fire        = (state == ISSUE) && op_valid_i;
    assign last_beat      = op_fire && (remaining == LEN_W'(1));
    assign drain_done     = (state == DRAIN) && (drain_cnt == 3'd0);
    assign res_fire       = (state == HOLD) && res_ready_i;
    assign dsp_feedback_o = 3'b000;
    assign dsp_subtract_o = 1'b0;

`ifdef DSP_MAC_SEQ_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              aborted;
    logic              res_err;

    // idle_cnt counts consecutive bubbles; the bubble that reaches the limit ends the job
    assign timeout_hit = (state == ISSUE) && !op_valid_i &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign res_err_o   = res_err;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            idle_cnt <= '0;
            aborted  <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                idle_cnt <= '0;
                aborted  <= 1'b0;
            end else if (state == ISSUE) begin
                if (op_fire)
                    idle_cnt <= '0;
                else if (timeout_hit)
                    aborted <= 1'b1;
                else
                    idle_cnt <= idle_cnt + 1'b1;
            end
            if (drain_done)
                res_err <= aborted;
            else if (res_fire)
                res_err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign res_err_o   = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nxt = ISSUE;
            ISSUE:   if (last_beat || timeout_hit) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 3'd0) state_nxt = HOLD;
            HOLD:    if (res_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            remaining         <= '0;
            first             <= 1'b0;
            drain_cnt         <= 3'd0;
            dsp_a_o           <= '0;
            dsp_b_o           <= '0;
            dsp_load_acc_o    <= 1'b0;
            dsp_unsigned_a_o  <= 1'b0;
            dsp_unsigned_b_o  <= 1'b0;
            dsp_shift_right_o <= '0;
            dsp_round_o       <= 1'b0;
            dsp_saturate_o    <= 1'b0;
            res_valid_o       <= 1'b0;
            res_data_o        <= '0;
        end else begin
            // Zero operands with load_acc=0 leave the accumulator untouched outside ISSUE
            dsp_a_o        <= '0;
            dsp_b_o        <= '0;
            dsp_load_acc_o <= 1'b0;

            if (cmd_fire) begin
                remaining         <= (cmd_len_i == '0) ? LEN_W'(1) : cmd_len_i;
                first             <= 1'b1;
                dsp_shift_right_o <= cmd_shift_i;
                dsp_round_o       <= cmd_round_i;
                dsp_saturate_o    <= cmd_sat_i;
                dsp_unsigned_a_o  <= cmd_unsigned_i[1];
                dsp_unsigned_b_o  <= cmd_unsigned_i[0];
            end

            // Bubbles before the first beat keep load_acc high so the accumulator holds zero
            if (state == ISSUE) begin
                dsp_load_acc_o <= first;
                if (op_fire) begin
                    dsp_a_o   <= op_a_i;
                    dsp_b_o   <= op_b_i;
                    first     <= 1'b0;
                    remaining <= remaining - 1'b1;
                end
            end

            if (last_beat || timeout_hit)
                drain_cnt <= 3'(DSP_LATENCY);
            else if (state == DRAIN && drain_cnt != 3'd0)
                drain_cnt <= drain_cnt - 1'b1;

            if (drain_done) begin
                res_data_o  <= dsp_z_i;
                res_valid_o <= 1'b1;
            end else if (res_fire) begin
                res_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_job_sequencer.sv
// Directed bench for dsp_mac_job_sequencer with a behavioural DSP accumulator model.
// Define DSP_MAC_SEQ_TIMEOUT_EN to also exercise the starvation abort.
module tb_dsp_mac_job_sequencer;

    localparam int LEN_W = 10;
    localparam int LAT   = 2;
    localparam int TMO   = 8;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [LEN_W-1:0]  cmd_len_i = '0;
    logic [5:0]        cmd_shift_i = '0;
    logic              cmd_round_i = 1'b0;
    logic              cmd_sat_i = 1'b0;
    logic [1:0]        cmd_unsigned_i = '0;
    logic              op_valid_i = 1'b0;
    logic              op_ready_o;
    logic [19:0]       op_a_i = '0;
    logic [17:0]       op_b_i = '0;
    logic [19:0]       dsp_a_o;
    logic [17:0]       dsp_b_o;
    logic              dsp_load_acc_o;
    logic [2:0]        dsp_feedback_o;
    logic              dsp_unsigned_a_o;
    logic              dsp_unsigned_b_o;
    logic [5:0]        dsp_shift_right_o;
    logic              dsp_round_o;
    logic              dsp_saturate_o;
    logic              dsp_subtract_o;
    logic [37:0]       dsp_z_i;
    logic              res_valid_o;
    logic              res_ready_i = 1'b0;
    logic [37:0]       res_data_o;
    logic              res_err_o;

    always #5 clock_i = ~clock_i;

    dsp_mac_job_sequencer #(
        .LEN_W(LEN_W), .DSP_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
        .cmd_shift_i(cmd_shift_i), .cmd_round_i(cmd_round_i), .cmd_sat_i(cmd_sat_i),
        .cmd_unsigned_i(cmd_unsigned_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .dsp_a_o(dsp_a_o), .dsp_b_o(dsp_b_o), .dsp_load_acc_o(dsp_load_acc_o),
        .dsp_feedback_o(dsp_feedback_o), .dsp_unsigned_a_o(dsp_unsigned_a_o),
        .dsp_unsigned_b_o(dsp_unsigned_b_o), .dsp_shift_right_o(dsp_shift_right_o),
        .dsp_round_o(dsp_round_o), .dsp_saturate_o(dsp_saturate_o),
        .dsp_subtract_o(dsp_subtract_o), .dsp_z_i(dsp_z_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_err_o(res_err_o)
    );

    // DSP model: accumulator register plus LAT-1 output stages, so z reflects a beat LAT edges later
    logic signed [37:0] prod;
    logic signed [37:0] acc_nxt;
    logic signed [37:0] acc = '0;
    logic signed [37:0] zq [LAT] = '{default: '0};

    assign prod    = $signed(dsp_a_o) * $signed(dsp_b_o);
    assign acc_nxt = dsp_load_acc_o ? prod : acc + prod;
    assign dsp_z_i = zq[LAT-1];

    always @(posedge clock_i) begin
        acc   <= acc_nxt;
        zq[0] <= acc_nxt;
        for (int i = 1; i < LAT; i++) zq[i] <= zq[i-1];
    end

    typedef struct packed {
        logic [9:0]         len;
        logic [2:0]         nops;
        logic [4:0][19:0]   a;
        logic [4:0][17:0]   b;
        logic [2:0]         gap_at;
        logic [3:0]         gap_len;
        logic [3:0]         hold;
        logic signed [37:0] exp;
    } job_t;

    job_t jobs [7];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   load_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clock_i);
        cyc++;
        if (dsp_load_acc_o) load_cnt++;
    endtask

    task automatic set_job(input int j, input int len, input int nops, input int gap_at,
                           input int gap_len, input int hold, input longint exp);
        jobs[j]         = '0;
        jobs[j].len     = 10'(len);
        jobs[j].nops    = 3'(nops);
        jobs[j].gap_at  = 3'(gap_at);
        jobs[j].gap_len = 4'(gap_len);
        jobs[j].hold    = 4'(hold);
        jobs[j].exp     = 38'(exp);
    endtask

    task automatic set_op(input int j, input int k, input int a, input int b);
        jobs[j].a[k] = 20'(a);
        jobs[j].b[k] = 18'(b);
    endtask

    task automatic run_job(input int j);
        int n;
        int hs_cyc;
        int guard;
        logic [37:0] held;
        n = int'(jobs[j].nops);
        hs_cyc = 0;
        load_cnt = 0;
        check("cmd_ready before job", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_len_i   = jobs[j].len;
        tick();
        cmd_valid_i = 1'b0;
        check("op_ready after accept", op_ready_o, 1);
        check("cmd_ready low in job", cmd_ready_o, 0);
        for (int k = 0; k < n; k++) begin
            if (jobs[j].gap_len != 0 && k == int'(jobs[j].gap_at)) begin
                op_valid_i = 1'b0;
                for (int g = 0; g < int'(jobs[j].gap_len); g++) begin
                    tick();
                    check("bubble dsp_a", dsp_a_o, 0);
                    check("bubble dsp_b", dsp_b_o, 0);
                end
            end
            op_valid_i = 1'b1;
            op_a_i = jobs[j].a[k];
            op_b_i = jobs[j].b[k];
            if (k == 0) hs_cyc = cyc;
            tick();
        end
        op_valid_i  = 1'b0;
        res_ready_i = (jobs[j].hold == 0);
        guard = 0;
        while (!res_valid_o && guard < 40) begin
            tick();
            guard++;
        end
        check("res_valid arrives", res_valid_o, 1);
        if (jobs[j].gap_len == 0) check("result latency", cyc - hs_cyc, n + LAT + 1);
        check("res_data", $signed(res_data_o), $signed(jobs[j].exp));
        check("res_err", res_err_o, 0);
        check("load_acc pulses", load_cnt, 1);
        check("cmd_ready low with result", cmd_ready_o, 0);
        held = res_data_o;
        for (int h = 0; h < int'(jobs[j].hold); h++) begin
            tick();
            check("held res_data", res_data_o, held);
            check("held res_valid", res_valid_o, 1);
            check("held cmd_ready", cmd_ready_o, 0);
        end
        res_ready_i = 1'b1;
        tick();
        check("res_valid drops", res_valid_o, 0);
        check("cmd_ready after handshake", cmd_ready_o, 1);
    endtask

    initial begin
        set_job(0, 4, 4, 7, 0, 0, 20);
        set_op(0, 0, 1, 1);  set_op(0, 1, 2, 3);  set_op(0, 2, 4, 5);  set_op(0, 3, -1, 7);
        set_job(1, 3, 3, 1, 5, 0, 113);
        set_op(1, 0, 10, 10); set_op(1, 1, 3, 3); set_op(1, 2, 2, 2);
        set_job(2, 0, 1, 7, 0, 0, 64'sd68719476736);
        set_op(2, 0, -524288, -131072);
        set_job(3, 2, 2, 7, 0, 10, -59944);
        set_op(3, 0, 300, -200); set_op(3, 1, 7, 8);
        set_job(4, 1, 1, 7, 0, 0, -18);
        set_op(4, 0, -2, 9);
        set_job(5, 5, 5, 7, 0, 0, -131068);
        set_op(5, 0, 524287, 131071); set_op(5, 1, -524288, 131071);
        set_op(5, 2, 1, 1); set_op(5, 3, 1, 1); set_op(5, 4, 1, 1);
        set_job(6, 1, 1, 7, 0, 0, 42);
        set_op(6, 0, 6, 7);

        reset_i = 1'b1;
        repeat (3) tick();
        check("rst cmd_ready", cmd_ready_o, 1);
        check("rst op_ready", op_ready_o, 0);
        check("rst res_valid", res_valid_o, 0);
        check("rst res_data", res_data_o, 0);
        check("rst res_err", res_err_o, 0);
        check("rst dsp_a", dsp_a_o, 0);
        check("rst dsp_b", dsp_b_o, 0);
        check("rst load_acc", dsp_load_acc_o, 0);
        check("rst shift", dsp_shift_right_o, 0);
        check("feedback const", dsp_feedback_o, 0);
        check("subtract const", dsp_subtract_o, 0);
        reset_i = 1'b0;
        tick();
        check("idle cmd_ready", cmd_ready_o, 1);

        for (int j = 0; j < 6; j++) run_job(j);

        // Config latch, then reset part-way through a five-beat job
        cmd_valid_i = 1'b1;  cmd_len_i = 10'd5;  cmd_shift_i = 6'd9;
        cmd_round_i = 1'b1;  cmd_sat_i = 1'b1;   cmd_unsigned_i = 2'b11;
        tick();
        cmd_valid_i = 1'b0;  cmd_shift_i = 6'd0;  cmd_round_i = 1'b0;
        cmd_sat_i = 1'b0;    cmd_unsigned_i = 2'b00;
        check("cfg shift", dsp_shift_right_o, 9);
        check("cfg round", dsp_round_o, 1);
        check("cfg sat", dsp_saturate_o, 1);
        check("cfg unsigned", {dsp_unsigned_a_o, dsp_unsigned_b_o}, 3);
        op_valid_i = 1'b1;  op_a_i = 20'd1;  op_b_i = 18'd2;
        tick();
        op_a_i = 20'd3;  op_b_i = 18'd4;
        tick();
        op_valid_i = 1'b0;
        check("cfg shift mid-job", dsp_shift_right_o, 9);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("mid rst cmd_ready", cmd_ready_o, 1);
        check("mid rst op_ready", op_ready_o, 0);
        check("mid rst res_valid", res_valid_o, 0);
        check("mid rst shift", dsp_shift_right_o, 0);
        check("mid rst dsp_a", dsp_a_o, 0);
        tick();
        check("post rst res_valid", res_valid_o, 0);
        run_job(6);

`ifdef DSP_MAC_SEQ_TIMEOUT_EN
        begin
            int guard;
            cmd_valid_i = 1'b1;  cmd_len_i = 10'd3;
            tick();
            cmd_valid_i = 1'b0;
            op_valid_i = 1'b1;  op_a_i = 20'd5;  op_b_i = 18'd5;
            tick();
            op_valid_i = 1'b0;
            res_ready_i = 1'b1;
            guard = 0;
            while (!res_valid_o && guard < 40) begin
                tick();
                guard++;
            end
            check("timeout res_valid", res_valid_o, 1);
            check("timeout res_data", $signed(res_data_o), 25);
            check("timeout res_err", res_err_o, 1);
            tick();
            check("timeout err clears", res_err_o, 0);
            check("timeout valid clears", res_valid_o, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_mac_job_sequencer.md
Name: dsp_mac_job_sequencer

Overview:
- Sequences one dsp_t1_20x18x64_cfg_ports instance through multiply-accumulate jobs.
- Accepts a job command, then streams N operand pairs into the DSP with correct load_acc framing and zero-fill on bubbles.
- Waits out the DSP pipeline and returns one 38-bit result per job through a valid/ready handshake.
- Sits between a streaming front end (filter/matrix engine) and the DSP primitive wrapper.

Parameters:
- LEN_W, 10, width of job length field; job length range is 1..2^LEN_W-1.
- DSP_LATENCY, 2, cycles from the DSP input beat to z_o reflecting it; legal range 1..7.
- TIMEOUT_CYCLES, 255, starvation limit used only when the optional feature is compiled in.

Ports:
- clock_i  in  1  single clock; all logic is rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  job command valid.
- cmd_ready_o  out  1  sequencer idle and able to accept a command.
- cmd_len_i  in  LEN_W  number of operand pairs; 0 is treated as 1.
- cmd_shift_i  in  6  shift_right value for the job.
- cmd_round_i  in  1  round enable for the job.
- cmd_sat_i  in  1  saturate enable for the job.
- cmd_unsigned_i  in  2  {unsigned_a, unsigned_b} for the job.
- op_valid_i  in  1  operand pair valid.
- op_ready_o  out  1  operand accepted this cycle.
- op_a_i  in  20  multiplicand.
- op_b_i  in  18  multiplier.
- dsp_a_o  out  20  to DSP a_i.
- dsp_b_o  out  18  to DSP b_i.
- dsp_load_acc_o  out  1  to DSP load_acc_i.
- dsp_feedback_o  out  3  to DSP feedback_i; constant 3'b000.
- dsp_unsigned_a_o, dsp_unsigned_b_o  out  1 each  to DSP.
- dsp_shift_right_o  out  6  to DSP.
- dsp_round_o, dsp_saturate_o  out  1 each  to DSP.
- dsp_subtract_o  out  1  constant 0.
- dsp_z_i  in  38  from DSP z_o.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumed.
- res_data_o  out  38  captured accumulator value.
- res_err_o  out  1  job aborted (only driven non-zero when the optional feature is compiled in).

Behaviour:
- Reset: state=IDLE; cmd_ready_o=1; op_ready_o=0; res_valid_o=0; res_data_o=0; res_err_o=0; dsp_a_o=0; dsp_b_o=0; dsp_load_acc_o=0; all config outputs=0.
- DSP accumulator semantics: load_acc=1 means acc := a*b; load_acc=0 means acc := acc + a*b.
- All dsp_* outputs are registered.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch len (0 promoted to 1) and config; remaining:=len; first:=1; go to ISSUE.
- ISSUE:
  - op_ready_o=1.
  - On op_valid_i: dsp_a_o/dsp_b_o := operands; dsp_load_acc_o := first; first:=0; remaining decrements.
  - If no op_valid_i (bubble): dsp_a_o=0, dsp_b_o=0, dsp_load_acc_o=first. This keeps the accumulator unchanged, or holds 0 before the first beat.
  - When the last beat is accepted (remaining==1), go to DRAIN with drain counter := DSP_LATENCY.
- DRAIN:
  - op_ready_o=0; dsp_a_o/dsp_b_o forced 0; dsp_load_acc_o=0.
  - Counter decrements each cycle.
  - At 0, capture dsp_z_i into res_data_o, set res_valid_o=1, go to HOLD.
- HOLD:
  - res_data_o stable until res_valid_o && res_ready_i.
  - On that handshake: res_valid_o=0 next cycle, go to IDLE.
  - No same-cycle command acceptance in HOLD: cmd_ready_o rises the cycle after the handshake.
- Config outputs stay constant from command accept until the next command; they never change mid-job.
- Throughput: job of N beats with no bubbles → result valid N+DSP_LATENCY+1 cycles after the first operand handshake.
- reset_i mid-job: immediately returns to the reset state. The partial accumulation and any pending result are discarded. The next job's first beat reloads the accumulator via load_acc.
- cmd_valid_i outside IDLE is ignored (cmd_ready_o=0). op_valid_i outside ISSUE is ignored.

Optional Feature:
- Macro: DSP_MAC_SEQ_TIMEOUT_EN.
- When defined:
  - ISSUE counts consecutive cycles without op_valid_i; the counter resets on each accepted beat.
  - Reaching TIMEOUT_CYCLES goes to DRAIN early.
  - The result is delivered with res_err_o=1 and res_data_o = accumulated partial sum.
  - res_err_o clears on the result handshake.
- When undefined: no counter is built, ISSUE waits indefinitely, and res_err_o is tied 0.

Test Plan:
- Reset, then cmd len=4, ops (1,1),(2,3),(4,5),(-1,7) back-to-back, res_ready_i=1 → res_data_o=20, res_err_o=0, valid at cycle 4+DSP_LATENCY+1 after the first op.
- cmd len=3 with a 5-cycle bubble between beats 1 and 2, ops (10,10),(3,3),(2,2) → res_data_o=113; during bubbles dsp_a_o=0, dsp_b_o=0.
- cmd len=0, op (−524288, −131072) signed → treated as len 1, res_data_o=68719476736; load_acc pulsed exactly once.
- Two jobs with res_ready_i held 0 for 10 cycles after the first → res_data_o stable, cmd_ready_o=0 throughout, second job result independent of the first (load_acc=1 on its first beat).
- reset_i asserted after 2 of 5 beats, then new job len=1 op (6,7) → res_data_o=42, no stale result emitted.
- (DSP_MAC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8) len=3, only op (5,5) supplied → after 8 idle cycles res_data_o=25, res_err_o=1.
